dac_write_arbiter: RTL and testbench
====================================

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`; reset `rst`, asynchronous and active-low.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- SETUP_CYC, 4, cycles with CS low and D/AB stable before WR falls.
- WR_CYC, 8, cycles WR is held low.
- HOLD_CYC, 2, cycles with D/AB/CS held after WR rises.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  async active-low reset.
- req_a  in  1  channel-A write request, level.
- data_a  in  8  channel-A sample.
- ack_a  out  1  channel-A write done, 1-cycle pulse.
- req_b  in  1  channel-B write request, level.
- data_b  in  8  channel-B sample.
- ack_b  out  1  channel-B write done, 1-cycle pulse.
- AB  out  1  DAC channel select, 0=A, 1=B.
- CS  out  1  DAC chip select, active-low.
- WR  out  1  DAC write strobe, active-low.
- LDAC  out  1  DAC latch strobe, active-low.
- D  out  8  DAC data bus.
- busy  out  1  transaction in progress.
REQ-004 All outputs SHALL be registered.
REQ-005 SETUP_CYC, WR_CYC and HOLD_CYC SHALL each be >= 1; the internal cycle counter SHALL be 8 bits wide.

Function
REQ-006 The FSM SHALL have five states: IDLE, SETUP, STROBE, HOLD, LOAD.
REQ-007 IDLE: on a cycle with any req high, the block SHALL grant one requester, latch its data into D, drive AB = granted channel, drive CS=0, busy=1, and enter SETUP.
REQ-008 Arbitration SHALL be round-robin:
- Only one requester high: that requester is granted.
- Both high: the requester not granted last is granted.
- last_grant resets to B, so A wins the first tie.
REQ-009 SETUP SHALL last SETUP_CYC cycles with WR=1, then go to STROBE.
REQ-010 STROBE SHALL last WR_CYC cycles with WR=0, then go to HOLD.
REQ-011 HOLD SHALL last HOLD_CYC cycles with WR=1 and CS=0, then go to LOAD.
REQ-012 LOAD SHALL last exactly 1 cycle: LDAC=0, CS=1, and the granted ack=1; the next state is IDLE.
REQ-013 D and AB SHALL remain constant from the grant cycle through the end of LOAD; req/data changes during a transaction SHALL be ignored.
REQ-014 Latency: with req sampled high at edge 0, the outputs SHALL be:
- CS low from edge 1.
- WR low for edges 1+SETUP_CYC to SETUP_CYC+WR_CYC.
- ack and LDAC low at edge 1+SETUP_CYC+WR_CYC+HOLD_CYC.
REQ-015 In the IDLE cycle following LOAD, the block SHALL arbitrate again. A requester that drops req on the edge where it samples ack=1 SHALL NOT receive a second write.
REQ-016 A req deasserted mid-transaction SHALL NOT abort it; the transaction SHALL complete and ack SHALL still pulse.
REQ-017 ack_a and ack_b SHALL never be high simultaneously, and neither SHALL be high outside LOAD.
REQ-018 In IDLE the outputs SHALL be: CS=1, WR=1, LDAC=1, busy=0, ack_a=ack_b=0; D and AB hold their last values.

Reset
REQ-019 While rst=0 the block SHALL immediately force: state=IDLE, counter=0, CS=1, WR=1, LDAC=1, D=8'h00, AB=0, ack_a=ack_b=0, busy=0, last_grant=B.
REQ-020 Reset asserted mid-transaction SHALL abort it without ack. After release, a still-high req SHALL start a fresh transaction.

Verification
REQ-021 The bench SHALL cover these directed scenarios (default parameters):
- Single A: req_a=1, data_a=8'h5A at edge 0 -> AB=0, D=5A, CS=0 at edge 1; WR=0 for edges 5-12; LDAC=0 and ack_a=1 at edge 15 only.
- Tie: req_a=req_b=1 from reset -> A granted first (D=data_a, AB=0); B granted in the IDLE after A's LOAD (AB=1); two ack pulses, A then B.
- Fairness: both held high for 4 transactions -> grant order A,B,A,B; no write is issued twice.
- Data change: data_a changes 8'h10 -> 8'hFF during STROBE -> D stays 8'h10 through LOAD.
- Reset mid-STROBE: rst=0 at edge 8 -> CS=WR=LDAC=1, D=00, no ack. After release with req_b=1 -> a full B transaction.
- Early drop: req_b dropped during SETUP -> the transaction completes and ack_b pulses once.

Source files
------------

// File: rtl/dac_write_arbiter.sv
// Two-channel round-robin write arbiter for a shared parallel DAC.
// Generates CS/WR/LDAC timing from a five-state FSM; every output is registered.
module dac_write_arbiter #(
  parameter int SETUP_CYC = 4,
  parameter int WR_CYC    = 8,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       AB,
  output logic       CS,
  output logic       WR,
  output logic       LDAC,
  output logic [7:0] D,
  output logic       busy
);

  localparam logic [7:0] L_SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] L_STROBE_LAST = 8'(WR_CYC - 1);
  localparam logic [7:0] L_HOLD_LAST   = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_LOAD
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_last_b, w_last_b_next;
  logic       r_ack_a, w_ack_a_next;
  logic       r_ack_b, w_ack_b_next;
  logic       r_ab, w_ab_next;
  logic       r_cs, w_cs_next;
  logic       r_wr, w_wr_next;
  logic       r_ldac, w_ldac_next;
  logic [7:0] r_d, w_d_next;
  logic       r_busy, w_busy_next;
  logic       w_grant_b;

  // On a tie the channel that did not win last time gets the bus.
  assign w_grant_b = (req_a && req_b) ? ~r_last_b : req_b;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_last_b_next = r_last_b;
    w_ack_a_next  = 1'b0;
    w_ack_b_next  = 1'b0;
    w_ab_next     = r_ab;
    w_cs_next     = r_cs;
    w_wr_next     = 1'b1;
    w_ldac_next   = 1'b1;
    w_d_next      = r_d;
    w_busy_next   = r_busy;
    case (r_state)
      S_IDLE: begin
        w_cs_next   = 1'b1;
        w_busy_next = 1'b0;
        if (req_a || req_b) begin
          w_last_b_next = w_grant_b;
          w_ab_next     = w_grant_b;
          w_d_next      = w_grant_b ? data_b : data_a;
          w_cs_next     = 1'b0;
          w_busy_next   = 1'b1;
          w_cnt_next    = 8'd0;
          w_state_next  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == L_SETUP_LAST) begin
          w_cnt_next   = 8'd0;
          w_wr_next    = 1'b0;
          w_state_next = S_STROBE;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == L_STROBE_LAST) begin
          w_cnt_next   = 8'd0;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          w_wr_next  = 1'b0;
        end
      end
      S_HOLD: begin
        if (r_cnt == L_HOLD_LAST) begin
          w_cnt_next   = 8'd0;
          w_cs_next    = 1'b1;
          w_ldac_next  = 1'b0;
          w_ack_a_next = ~r_ab;
          w_ack_b_next = r_ab;
          w_state_next = S_LOAD;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_LOAD: begin
        w_cs_next    = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_cs_next    = 1'b1;
        w_busy_next  = 1'b0;
        w_cnt_next   = 8'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_last_b <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_ab     <= 1'b0;
      r_cs     <= 1'b1;
      r_wr     <= 1'b1;
      r_ldac   <= 1'b1;
      r_d      <= 8'h00;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_last_b <= w_last_b_next;
      r_ack_a  <= w_ack_a_next;
      r_ack_b  <= w_ack_b_next;
      r_ab     <= w_ab_next;
      r_cs     <= w_cs_next;
      r_wr     <= w_wr_next;
      r_ldac   <= w_ldac_next;
      r_d      <= w_d_next;
      r_busy   <= w_busy_next;
    end
  end

  assign ack_a = r_ack_a;
  assign ack_b = r_ack_b;
  assign AB    = r_ab;
  assign CS    = r_cs;
  assign WR    = r_wr;
  assign LDAC  = r_ldac;
  assign D     = r_d;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter: a time-since-grant model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dac_write_arbiter;

  localparam int SETUP = 4;
  localparam int WRC   = 8;
  localparam int HOLD  = 2;
  localparam int TOTAL = SETUP + WRC + HOLD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       req_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       ack_a, ack_b, AB, CS, WR, LDAC, busy;
  logic [7:0] D;

  int n_chk = 0;
  int n_fail = 0;

  dac_write_arbiter #(.SETUP_CYC(SETUP), .WR_CYC(WRC), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .AB(AB), .CS(CS), .WR(WR), .LDAC(LDAC), .D(D), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a transaction is just "cycles elapsed since the grant edge".
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic       m_ch = 1'b0;
  logic       m_last = 1'b1;
  logic [7:0] m_d = 8'h00;

  function automatic logic pick_b(input logic a, input logic b, input logic last_b);
    if (a && b) return !last_b;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_ch     <= 1'b0;
      m_last   <= 1'b1;
      m_d      <= 8'h00;
    end else if (m_active) begin
      if (m_t == TOTAL) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end else if (req_a || req_b) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_ch     <= pick_b(req_a, req_b, m_last);
      m_last   <= pick_b(req_a, req_b, m_last);
      m_d      <= pick_b(req_a, req_b, m_last) ? data_b : data_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [31:0] got, exp;
    logic e_cs, e_wr, e_ldac, e_load;
    forever begin
      @(negedge clk);
      e_cs   = !(m_active && m_t <= SETUP + WRC + HOLD);
      e_wr   = !(m_active && m_t > SETUP && m_t <= SETUP + WRC);
      e_load = m_active && m_t == TOTAL;
      e_ldac = !e_load;
      got = {17'b0, ack_a, ack_b, AB, CS, WR, LDAC, busy, D};
      exp = {17'b0, e_load && !m_ch, e_load && m_ch, m_ch, e_cs, e_wr, e_ldac, m_active, m_d};
      chk("model_cycle", got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 32'({CS, WR, LDAC, busy, ack_a, ack_b, AB}), 32'b1110000);
    chk("reset_D", 32'(D), 32'h00);
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // Returns channel of the next ack pulse, with D/AB seen during LOAD, then
  // resumes 2 time units after the edge that leaves LOAD.
  task automatic wait_ack(output int ch, output logic [7:0] d_seen, output logic ab_seen);
    ch = -1; d_seen = 8'h00; ab_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        ch = ack_b ? 1 : 0;
        d_seen = D;
        ab_seen = AB;
        break;
      end
    end
    if (ch < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected one within 40 cycles");
    end
    @(posedge clk); #2;
  endtask

  task automatic no_more_acks(input int cycles);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) cnt++;
    end
    chk("no_extra_ack", 32'(cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    logic [7:0] dv;
    logic abv;
    fork
      compare_loop();
    join_none

    // Single A: literal waveform table, k = edge index of observation.
    do_reset();
    req_a = 1'b1; data_a = 8'h5A;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("singleA_k%0d", k), 32'({CS, WR, LDAC, ack_a, ack_b}),
          32'({(k >= 1 && k <= 14) ? 1'b0 : 1'b1,
               (k >= 5 && k <= 12) ? 1'b0 : 1'b1,
               (k == 15) ? 1'b0 : 1'b1,
               (k == 15) ? 1'b1 : 1'b0,
               1'b0}));
      if (k == 1) chk("singleA_D_AB", 32'({AB, D}), 32'({1'b0, 8'h5A}));
      if (k == 15) req_a = 1'b0;
    end
    no_more_acks(5);

    // Tie from reset: A first, then B.
    do_reset();
    data_a = 8'h11; data_b = 8'h22; req_a = 1'b1; req_b = 1'b1;
    wait_ack(ch, dv, abv);
    chk("tie_first_ch", 32'(ch), 32'd0);
    chk("tie_first_D_AB", 32'({abv, dv}), 32'({1'b0, 8'h11}));
    wait_ack(ch, dv, abv);
    req_a = 1'b0; req_b = 1'b0;
    chk("tie_second_ch", 32'(ch), 32'd1);
    chk("tie_second_D_AB", 32'({abv, dv}), 32'({1'b1, 8'h22}));
    no_more_acks(20);

    // Fairness: four back-to-back grants alternate A,B,A,B.
    do_reset();
    data_a = 8'hA1; data_b = 8'hB2; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ch, dv, abv);
      chk($sformatf("fair_order%0d", i), 32'(ch), 32'(i % 2));
    end
    req_a = 1'b0; req_b = 1'b0;
    no_more_acks(20);

    // Data change during STROBE is ignored.
    do_reset();
    req_a = 1'b1; data_a = 8'h10;
    repeat (7) @(posedge clk);
    #2 data_a = 8'hFF;
    wait_ack(ch, dv, abv);
    req_a = 1'b0;
    chk("datachg_ch", 32'(ch), 32'd0);
    chk("datachg_D_load", 32'(dv), 32'h10);

    // Reset during STROBE aborts; fresh B transaction afterwards.
    do_reset();
    req_a = 1'b1; data_a = 8'h77;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 32'({CS, WR, LDAC, busy, ack_a, ack_b}), 32'b111000);
    chk("abort_D", 32'(D), 32'h00);
    req_a = 1'b0; req_b = 1'b1; data_b = 8'hC3;
    @(posedge clk); #2 rst = 1'b1;
    wait_ack(ch, dv, abv);
    req_b = 1'b0;
    chk("abort_then_B_ch", 32'(ch), 32'd1);
    chk("abort_then_B_D", 32'({abv, dv}), 32'({1'b1, 8'hC3}));
    no_more_acks(5);

    // Early drop during SETUP still completes with one ack.
    do_reset();
    req_b = 1'b1; data_b = 8'h33;
    repeat (2) @(posedge clk);
    #2 req_b = 1'b0;
    wait_ack(ch, dv, abv);
    chk("early_drop_ch", 32'(ch), 32'd1);
    chk("early_drop_D", 32'(dv), 32'h33);
    no_more_acks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
